// File: rtl/alu_control_unit.sv
// alu_control_unit: sequencer for the arithmetic_unit datapath.
// Loads two operands over the shared in bus, then steps the datapath through
// add/sub (done after load), radix-2 Booth multiply or restoring divide.
//
// Operand handshake: o_in_ready is high only in LOAD_M and LOAD_Q; an operand
// is consumed on a cycle where i_in_valid && o_in_ready, and that same cycle
// asserts the matching load line (c[0] for M, c[1] for Q). With i_in_valid
// low the FSM waits in the load state with every control line at 0.
module alu_control_unit #(
    parameter int ITER = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic       i_cnt_done,
    input  logic       i_q0,
    input  logic       i_qm1,
    input  logic       i_a7,
    output logic [1:0] o_op_out,
    output logic [7:0] o_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_res_valid,
    output logic [3:0] o_state
);

    // The iteration count lives in the datapath's 3-bit counter; this
    // sequencer only watches cnt_done, so any other value cannot work.
    if (ITER != 8) begin : g_iter_check
        $error("alu_control_unit: ITER must be 8 to match the datapath counter");
    end

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_M    = 4'd1,
        ST_LOAD_Q    = 4'd2,
        ST_B_EVAL    = 4'd3,
        ST_B_ADD     = 4'd4,
        ST_B_SHIFT   = 4'd5,
        ST_D_SHIFT   = 4'd6,
        ST_D_SUB     = 4'd7,
        ST_D_TEST    = 4'd8,
        ST_D_RESTORE = 4'd9,
        ST_D_FINAL   = 4'd10,
        ST_DONE      = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic       r_busy;
    logic       r_res_valid;
    logic       r_qbit;      // divide quotient bit awaiting its shift into Q
    logic       r_last;      // set on the divide's final D_SHIFT
    logic       r_bsub;      // Booth step kind chosen in B_EVAL: 1 = A-M
    logic [6:0] w_c;         // c[6:0]; c[7] is derived from the result flag

    // State register plus the small amount of sequencing state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 2'b00;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_qbit      <= 1'b0;
            r_last      <= 1'b0;
            r_bsub      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_start) begin
                r_op        <= i_op;
                r_busy      <= 1'b1;
                r_res_valid <= 1'b0;
            end
            if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
            if (w_next == ST_DONE) begin
                r_res_valid <= 1'b1;
            end
            if (r_state == ST_B_EVAL) begin
                r_bsub <= i_q0 & ~i_qm1;
            end
            if (r_state == ST_D_SHIFT) begin
                r_last <= i_cnt_done;
            end
            if (r_state == ST_D_TEST) begin
                r_qbit <= ~i_a7;
            end
            if (r_state == ST_D_FINAL) begin
                r_qbit <= 1'b0;
            end
        end
    end

    // Next-state decode and per-state control lines.
    always_comb begin
        w_next     = r_state;
        w_c        = 7'b0;
        o_in_ready = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = ST_LOAD_M;
            end
            ST_LOAD_M: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_c[0] = 1'b1;
                    w_next = ST_LOAD_Q;
                end
            end
            ST_LOAD_Q: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_c[1] = 1'b1;
                    if (!r_op[1])      w_next = ST_DONE;
                    else if (!r_op[0]) w_next = ST_B_EVAL;
                    else               w_next = ST_D_SHIFT;
                end
            end
            ST_B_EVAL: begin
                if (i_q0 ^ i_qm1) w_next = ST_B_ADD;
                else              w_next = ST_B_SHIFT;
            end
            ST_B_ADD: begin
                w_c[2] = 1'b1;
                w_c[3] = r_bsub;
                w_next = ST_B_SHIFT;
            end
            ST_B_SHIFT: begin
                w_c[4] = 1'b1;
                w_c[5] = 1'b1;
                w_c[6] = i_a7;
                w_next = i_cnt_done ? ST_DONE : ST_B_EVAL;
            end
            ST_D_SHIFT: begin
                w_c[4] = 1'b1;
                w_c[5] = 1'b1;
                w_c[6] = r_qbit;
                w_next = ST_D_SUB;
            end
            ST_D_SUB: begin
                w_c[2] = 1'b1;
                w_c[3] = 1'b1;
                w_next = ST_D_TEST;
            end
            ST_D_TEST: begin
                if (i_a7)        w_next = ST_D_RESTORE;
                else if (r_last) w_next = ST_D_FINAL;
                else             w_next = ST_D_SHIFT;
            end
            ST_D_RESTORE: begin
                w_c[2] = 1'b1;
                w_next = r_last ? ST_D_FINAL : ST_D_SHIFT;
            end
            ST_D_FINAL: begin
                // Last left shift brings the final quotient bit into Q[0].
                w_c[4] = 1'b1;
                w_c[6] = r_qbit;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Mul/div results sit in the A:Q registers, so c[7] gates them onto z.
    assign o_c         = {r_res_valid & r_op[1], w_c};
    assign o_op_out    = r_op;
    assign o_busy      = r_busy;
    assign o_res_valid = r_res_valid;
    assign o_state     = r_state;

endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed tests of the sequencer against a small
// behavioural model of the arithmetic_unit datapath it controls.
module tb_alu_control_unit;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_M    = 4'd1;
    localparam logic [3:0] S_LOAD_Q    = 4'd2;
    localparam logic [3:0] S_B_ADD     = 4'd4;
    localparam logic [3:0] S_B_SHIFT   = 4'd5;
    localparam logic [3:0] S_D_SHIFT   = 4'd6;
    localparam logic [3:0] S_D_FINAL   = 4'd10;
    localparam logic [3:0] S_DONE      = 4'd11;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       in_valid;
    logic [7:0] in_bus;
    logic       in_ready;
    logic       cnt_done, q0, qm1, a7;
    logic [1:0] op_out;
    logic [7:0] c;
    logic       busy, done, res_valid;
    logic [3:0] st;

    int total = 0;
    int bad   = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_control_unit #(.ITER(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_cnt_done(cnt_done), .i_q0(q0), .i_qm1(qm1), .i_a7(a7),
        .o_op_out(op_out), .o_c(c), .o_busy(busy), .o_done(done),
        .o_res_valid(res_valid), .o_state(st)
    );

    // datapath model: M, A, Q, Q[-1], 3-bit counter
    logic [7:0]  m_m, m_a, m_q;
    logic        m_qm1;
    logic [2:0]  m_cnt;
    logic [15:0] z;

    always @(posedge clk) begin
        if (rst) begin
            m_m <= 8'h00; m_a <= 8'h00; m_q <= 8'h00; m_qm1 <= 1'b0; m_cnt <= 3'd0;
        end else if (c[0]) begin
            m_m <= in_bus; m_a <= 8'h00; m_q <= 8'h00; m_qm1 <= 1'b0; m_cnt <= 3'd0;
        end else begin
            if (c[1]) m_q <= in_bus;
            if (c[2]) m_a <= c[3] ? (m_a - m_m) : (m_a + m_m);
            if (c[4]) begin
                if (op_out == 2'b10) {m_a, m_q, m_qm1} <= {c[6], m_a, m_q};
                else                 {m_a, m_q} <= {m_a[6:0], m_q, c[6]};
            end
            if (c[5]) m_cnt <= m_cnt + 3'd1;
        end
    end

    assign cnt_done = (m_cnt == 3'd7);
    assign q0       = m_q[0];
    assign qm1      = m_qm1;
    assign a7       = m_a[7];
    assign z = c[7] ? {m_a, m_q}
                    : ((op_out == 2'b00) ? {8'h00, m_m + m_q} : {8'h00, m_m - m_q});

    // driver: start, M, Q; returns at the negedge of the first cycle after LOAD_Q
    task automatic load_ops(input logic [1:0] o, input logic [7:0] mv, input logic [7:0] qv);
        @(negedge clk); start = 1'b1; op = o; in_valid = 1'b0;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_bus = mv;
        @(negedge clk); in_bus = qv;
        @(negedge clk); in_valid = 1'b0;
    endtask

    // driver: step until DONE, collecting per-state statistics
    task automatic run_to_done(output int n_cyc, output int n_shift, output int n_add,
                               output int n_final, output logic [7:0] c3_seq, output logic to);
        n_cyc = 1; n_shift = 0; n_add = 0; n_final = 0; c3_seq = 8'h00; to = 1'b1;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (st == S_DONE) begin
                to = 1'b0;
                break;
            end
            if (st == S_B_SHIFT || st == S_D_SHIFT) n_shift++;
            if (st == S_B_ADD) begin
                n_add++;
                c3_seq = {c3_seq[6:0], c[3]};
            end
            if (st == S_D_FINAL) n_final++;
            @(negedge clk);
            n_cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", st, S_IDLE); end
        total++; if ({c, busy, done, res_valid, in_ready, op_out} !== 14'h0) begin
            bad++; $display("FAIL reset_outputs got c=%h busy=%b done=%b rv=%b rdy=%b op=%b exp all 0",
                            c, busy, done, res_valid, in_ready, op_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        @(negedge clk); start = 1'b1; op = 2'b00; in_valid = 1'b1; in_bus = 8'd5;
        @(negedge clk); start = 1'b0; #1;
        total++; if (st !== S_LOAD_M || c !== 8'h01 || in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL add_load_m got st=%0d c=%h rdy=%b busy=%b exp st=1 c=01 rdy=1 busy=1", st, c, in_ready, busy);
        end
        @(negedge clk); in_bus = 8'd3; #1;
        total++; if (st !== S_LOAD_Q || c !== 8'h02) begin
            bad++; $display("FAIL add_load_q got st=%0d c=%h exp st=2 c=02", st, c);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (st !== S_DONE || done !== 1'b1 || res_valid !== 1'b1 || c !== 8'h00) begin
            bad++; $display("FAIL add_done got st=%0d done=%b rv=%b c=%h exp st=11 done=1 rv=1 c=00", st, done, res_valid, c);
        end
        total++; if (z !== 16'h0008) begin bad++; $display("FAIL add_z got=%h exp=0008", z); end
        @(negedge clk); #1;
        total++; if (st !== S_IDLE || done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b1) begin
            bad++; $display("FAIL add_after got st=%0d done=%b busy=%b rv=%b exp st=0 done=0 busy=0 rv=1", st, done, busy, res_valid);
        end
    endtask

    task automatic test_sub();
        int n, ns, na, nf; logic [7:0] seq; logic to;
        load_ops(2'b01, 8'd9, 8'd4);
        run_to_done(n, ns, na, nf, seq, to);
        total++; if (to !== 1'b0 || n !== 1) begin bad++; $display("FAIL sub_latency got n=%0d to=%b exp n=1 to=0", n, to); end
        total++; if (z !== 16'h0005) begin bad++; $display("FAIL sub_z got=%h exp=0005", z); end
    endtask

    task automatic test_mul_neg();
        int n, ns, na, nf; logic [7:0] seq; logic to;
        load_ops(2'b10, 8'd7, 8'hFD);
        run_to_done(n, ns, na, nf, seq, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL mul_neg_timeout got=%b exp=0", to); end
        total++; if (ns !== 8) begin bad++; $display("FAIL mul_neg_shifts got=%0d exp=8", ns); end
        total++; if (na !== 3 || seq !== 8'h05) begin bad++; $display("FAIL mul_neg_adds got n=%0d c3=%h exp n=3 c3=05", na, seq); end
        total++; if (n - 1 !== 19) begin bad++; $display("FAIL mul_neg_cycles got=%0d exp=19", n - 1); end
        total++; if (z !== 16'hFFEB) begin bad++; $display("FAIL mul_neg_z got=%h exp=ffeb", z); end
        total++; if (done !== 1'b1 || res_valid !== 1'b1 || c[7] !== 1'b1) begin
            bad++; $display("FAIL mul_neg_done got done=%b rv=%b c7=%b exp 1 1 1", done, res_valid, c[7]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            total++; if (res_valid !== 1'b1 || c !== 8'h80 || busy !== 1'b0 || z !== 16'hFFEB) begin
                bad++; $display("FAIL mul_neg_hold got rv=%b c=%h busy=%b z=%h exp rv=1 c=80 busy=0 z=ffeb", res_valid, c, busy, z);
            end
        end
    endtask

    task automatic test_mul_alt();
        int n, ns, na, nf; logic [7:0] seq; logic to;
        load_ops(2'b10, 8'd3, 8'h55);
        #1;
        total++; if (res_valid !== 1'b0 || c[7] !== 1'b0) begin
            bad++; $display("FAIL mul_alt_rv_clear got rv=%b c7=%b exp 0 0", res_valid, c[7]);
        end
        run_to_done(n, ns, na, nf, seq, to);
        total++; if (to !== 1'b0 || n - 1 !== 24) begin bad++; $display("FAIL mul_alt_cycles got=%0d to=%b exp=24 to=0", n - 1, to); end
        total++; if (na !== 8 || seq !== 8'hAA) begin bad++; $display("FAIL mul_alt_adds got n=%0d c3=%h exp n=8 c3=aa", na, seq); end
        total++; if (z !== 16'h00FF) begin bad++; $display("FAIL mul_alt_z got=%h exp=00ff", z); end
    endtask

    task automatic test_div();
        int n, ns, na, nf; logic [7:0] seq; logic to;
        load_ops(2'b11, 8'd7, 8'd200);
        run_to_done(n, ns, na, nf, seq, to);
        total++; if (to !== 1'b0 || n < 26 || n > 34) begin bad++; $display("FAIL div_cycles got=%0d to=%b exp 26..34 to=0", n, to); end
        total++; if (ns !== 8 || nf !== 1) begin bad++; $display("FAIL div_shifts got shift=%0d final=%0d exp 8 1", ns, nf); end
        total++; if (z[7:0] !== 8'h1C) begin bad++; $display("FAIL div_quot got=%h exp=1c", z[7:0]); end
        total++; if (z[15:9] !== 7'd4 || z[8] !== 1'b0) begin bad++; $display("FAIL div_rem got=%0d z8=%b exp 4 0", z[15:9], z[8]); end
    endtask

    task automatic test_stall();
        @(negedge clk); start = 1'b1; op = 2'b00;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_bus = 8'd2;
        @(negedge clk); in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (st !== S_LOAD_Q || c !== 8'h00 || in_ready !== 1'b1) begin
                bad++; $display("FAIL stall_hold got st=%0d c=%h rdy=%b exp st=2 c=00 rdy=1", st, c, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b1; in_bus = 8'd6; #1;
        total++; if (c !== 8'h02) begin bad++; $display("FAIL stall_resume got c=%h exp=02", c); end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (st !== S_DONE || z !== 16'h0008) begin bad++; $display("FAIL stall_done got st=%0d z=%h exp st=11 z=0008", st, z); end
    endtask

    task automatic test_rst_mid_mul();
        load_ops(2'b10, 8'd7, 8'hFD);          // now cycle 3 after start
        @(negedge clk); start = 1'b1; op = 2'b11;
        @(negedge clk); start = 1'b0; #1;
        total++; if (st === S_LOAD_M || st === S_IDLE || op_out !== 2'b10 || busy !== 1'b1) begin
            bad++; $display("FAIL busy_start got st=%0d op=%b busy=%b exp mul running op=10 busy=1", st, op_out, busy);
        end
        repeat (5) @(negedge clk);              // cycle 10
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        total++; if (st !== S_IDLE || busy !== 1'b0 || c !== 8'h00 || op_out !== 2'b00 || res_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid got st=%0d busy=%b c=%h op=%b rv=%b done=%b rdy=%b exp all reset",
                            st, busy, c, op_out, res_valid, done, in_ready);
        end
        @(negedge clk); #1;
        total++; if (st !== S_IDLE) begin bad++; $display("FAIL rst_stays_idle got=%0d exp=0", st); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; in_valid = 1'b0; in_bus = 8'h00;
        test_reset();
        test_add();
        test_sub();
        test_mul_neg();
        test_mul_alt();
        test_div();
        test_stall();
        test_rst_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
